// File: rtl/moving_obstacle_ctrl.sv
// rtl/moving_obstacle_ctrl.sv - 2-D fixed-point obstacle mover with wall bounce, optional Y wrap and collision freeze
module moving_obstacle_ctrl #(
  parameter int INITIAL_X       = 100,
  parameter int INITIAL_Y       = 300,
  parameter int INITIAL_X_SPEED = 120,
  parameter int INITIAL_Y_SPEED = 0,
  parameter int SPEED_ADDITION  = 10,
  parameter int MAX_SPEED       = 160,
  parameter int OBJECT_WIDTH_X  = 64,
  parameter int OBJECT_HEIGHT_Y = 32,
  parameter int FRAME_W         = 640,
  parameter int FRAME_H         = 480,
  parameter int FP_SHIFT        = 6,
  parameter int FREEZE_FRAMES   = 8,
  parameter int Y_WRAP          = 0
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               collision,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               frozen,
  output logic [7:0]         hitCount
);

  localparam int FP_ONE   = 2 ** FP_SHIFT;
  localparam int INIT_XFP = INITIAL_X * FP_ONE;
  localparam int INIT_YFP = INITIAL_Y * FP_ONE;
  localparam int XMAX     = (FRAME_W - OBJECT_WIDTH_X) * FP_ONE;
  localparam int YMAX     = (FRAME_H - OBJECT_HEIGHT_Y) * FP_ONE;
  localparam int YTOP     = -(OBJECT_HEIGHT_Y * FP_ONE);
  localparam int YBOT     = FRAME_H * FP_ONE;
  localparam logic [7:0] FREEZE_INIT = 8'(FREEZE_FRAMES);

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  state_t             state_q;
  logic signed [31:0] pos_x_q, pos_y_q, speed_x_q, speed_y_q;
  logic [7:0]         freeze_q, hit_q;
  logic               coll_q;

  logic signed [31:0] nx, ny, pos_x_d, pos_y_d, speed_x_d, speed_y_d;
  logic               coll_evt;

  // Magnitude grows by SPEED_ADDITION up to MAX_SPEED; sign kept, zero stays zero.
  function automatic logic signed [31:0] bump(input logic signed [31:0] v);
    logic signed [31:0] m;
    m = (v < 0) ? -v : v;
    m = (m + SPEED_ADDITION > MAX_SPEED) ? MAX_SPEED : m + SPEED_ADDITION;
    if (v == 0)
      return 32'sd0;
    return (v < 0) ? -m : m;
  endfunction

  assign coll_evt = collision & ~coll_q;

  always_comb begin
    nx        = pos_x_q + speed_x_q;
    ny        = pos_y_q + speed_y_q;
    pos_x_d   = nx;
    speed_x_d = speed_x_q;
    pos_y_d   = ny;
    speed_y_d = speed_y_q;
    if (nx < 0) begin
      pos_x_d   = 0;
      speed_x_d = -speed_x_q;
    end else if (nx > XMAX) begin
      pos_x_d   = XMAX;
      speed_x_d = -speed_x_q;
    end
    if (Y_WRAP != 0) begin
      if (ny > YBOT)
        pos_y_d = YTOP;
      else if (ny < YTOP)
        pos_y_d = YBOT;
    end else begin
      if (ny < 0) begin
        pos_y_d   = 0;
        speed_y_d = -speed_y_q;
      end else if (ny > YMAX) begin
        pos_y_d   = YMAX;
        speed_y_d = -speed_y_q;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      pos_x_q   <= INIT_XFP;
      pos_y_q   <= INIT_YFP;
      speed_x_q <= INITIAL_X_SPEED;
      speed_y_q <= INITIAL_Y_SPEED;
      freeze_q  <= 8'd0;
      hit_q     <= 8'd0;
      coll_q    <= 1'b0;
    end else begin
      coll_q <= collision;
      if (!enable) begin
        state_q   <= IDLE;
        pos_x_q   <= INIT_XFP;
        pos_y_q   <= INIT_YFP;
        speed_x_q <= INITIAL_X_SPEED;
        speed_y_q <= INITIAL_Y_SPEED;
        freeze_q  <= 8'd0;
      end else begin
        case (state_q)
          IDLE: state_q <= RUN;
          RUN: begin
            // A collision edge beats a coincident frame tick: no move that frame.
            if (coll_evt) begin
              speed_x_q <= bump(speed_x_q);
              speed_y_q <= bump(speed_y_q);
              if (hit_q != 8'hFF)
                hit_q <= hit_q + 8'd1;
              freeze_q  <= FREEZE_INIT;
              state_q   <= FROZEN;
            end else if (startOfFrame) begin
              pos_x_q   <= pos_x_d;
              pos_y_q   <= pos_y_d;
              speed_x_q <= speed_x_d;
              speed_y_q <= speed_y_d;
            end
          end
          FROZEN: begin
            if (startOfFrame) begin
              if (freeze_q == 8'd1) begin
                freeze_q <= 8'd0;
                state_q  <= RUN;
              end else begin
                freeze_q <= freeze_q - 8'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign topLeftX = 11'(pos_x_q >>> FP_SHIFT);
  assign topLeftY = 11'(pos_y_q >>> FP_SHIFT);
  assign frozen   = (state_q == FROZEN);
  assign hitCount = hit_q;

endmodule

// File: tb/tb_moving_obstacle_ctrl.sv
// tb/tb_moving_obstacle_ctrl.sv - directed self-checking bench for moving_obstacle_ctrl
module tb_moving_obstacle_ctrl;

  logic clk, resetN, startOfFrame, enable, collision, enable2, collision2;
  logic signed [10:0] tlx, tly, tlx2, tly2;
  logic frozen, frozen2;
  logic [7:0] hits, hits2;
  int n_checks, n_fail;
  int sat_exp [4];

  moving_obstacle_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .collision(collision), .topLeftX(tlx), .topLeftY(tly), .frozen(frozen), .hitCount(hits)
  );

  moving_obstacle_ctrl #(.INITIAL_Y(480), .INITIAL_Y_SPEED(64), .Y_WRAP(1)) dut2 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable2),
    .collision(collision2), .topLeftX(tlx2), .topLeftY(tly2), .frozen(frozen2), .hitCount(hits2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic pulse();
    collision = 1'b1;
    tick();
    collision = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    sat_exp = '{140, 150, 160, 160};
    resetN = 1'b0; startOfFrame = 1'b0; enable = 1'b0; collision = 1'b0;
    enable2 = 1'b0; collision2 = 1'b0;
    tick();
    tick();
    check("reset_x", tlx, 100);
    check("reset_y", tly, 300);
    check("reset_frozen", frozen, 0);
    check("reset_hits", hits, 0);
    resetN = 1'b1;
    tick();

    enable = 1'b1;
    tick();
    frame();
    check("first_frame_x", tlx, 101);
    check("first_frame_y", tly, 300);

    // collision held high across the whole freeze
    collision = 1'b1;
    tick();
    check("hit1_count", hits, 1);
    check("hit1_frozen", frozen, 1);
    check("hit1_speed", dut.speed_x_q, 130);
    for (int i = 0; i < 7; i++) frame();
    check("freeze7_frozen", frozen, 1);
    check("freeze7_x", tlx, 101);
    frame();
    check("freeze8_frozen", frozen, 0);
    check("freeze8_x", tlx, 101);
    check("held_level_hits", hits, 1);
    collision = 1'b0;
    tick();
    frame();
    check("after_freeze_x", tlx, 103);

    for (int k = 0; k < 4; k++) begin
      pulse();
      check("sat_speed", dut.speed_x_q, sat_exp[k]);
      check("sat_hits", hits, k + 2);
      for (int i = 0; i < 8; i++) frame();
    end
    check("sat_unfrozen", frozen, 0);
    frame();
    check("sat_move_x", tlx, 106);

    pulse();
    check("pre_disable_frozen", frozen, 1);
    enable = 1'b0;
    tick();
    check("disable_frozen", frozen, 0);
    check("disable_x", tlx, 100);
    check("disable_speed", dut.speed_x_q, 120);
    check("disable_hits", hits, 6);
    pulse();
    check("idle_event_hits", hits, 6);

    enable = 1'b1;
    tick();
    for (int i = 0; i < 253; i++) frame();
    check("pre_wall_x", tlx, 574);
    frame();
    check("wall_x", tlx, 576);
    check("wall_speed", dut.speed_x_q, -120);
    frame();
    check("post_wall_x", tlx, 574);

    resetN = 1'b0;
    #1;
    check("async_reset_hits", hits, 0);
    check("async_reset_x", tlx, 100);
    enable = 1'b0;
    tick();
    resetN = 1'b1;
    tick();

    check("wrap_reset_y", tly2, 480);
    enable2 = 1'b1;
    tick();
    frame();
    check("wrap_y", tly2, -32);
    check("wrap_x", tlx2, 101);
    collision2 = 1'b1;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    collision2 = 1'b0;
    check("simul_frozen", frozen2, 1);
    check("simul_y", tly2, -32);
    check("simul_x", tlx2, 101);
    check("simul_hits", hits2, 1);
    check("simul_speed_y", dut2.speed_y_q, 74);
    for (int i = 0; i < 8; i++) frame();
    check("wrap_unfrozen", frozen2, 0);
    frame();
    check("wrap_floor_y", tly2, -31);
    check("wrap_move_x", tlx2, 103);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/moving_obstacle_ctrl.md
Name: moving_obstacle_ctrl

Overview:
Parametrised obstacle motion controller, successor to the single-axis obstacle mover. It integrates 2-D fixed-point position once per frame, using configurable frame size, object size and fixed-point resolution. X always bounces off the walls; Y either bounces or wraps, selected by parameter. On collision the speed magnitude rises with saturation and the obstacle freezes for N frames. It feeds topLeftX/topLeftY to the obstacle bitmap/draw block.

Parameters:
INITIAL_X, 100, reset/respawn X in pixels
INITIAL_Y, 300, reset/respawn Y in pixels
INITIAL_X_SPEED, 120, signed X speed, fixed-point units per frame
INITIAL_Y_SPEED, 0, signed Y speed, fixed-point units per frame
SPEED_ADDITION, 10, magnitude added per collision (applies to both axes)
MAX_SPEED, 160, saturation limit on speed magnitude, per axis
OBJECT_WIDTH_X, 64, object width in pixels
OBJECT_HEIGHT_Y, 32, object height in pixels
FRAME_W, 640, screen width in pixels
FRAME_H, 480, screen height in pixels
FP_SHIFT, 6, fixed-point fraction bits (multiplier = 2^FP_SHIFT)
FREEZE_FRAMES, 8, number of frames held frozen after a collision, range 1..255
Y_WRAP, 0, 0 = Y bounces, 1 = Y wraps from bottom to top

Ports:
clk  in  1  system clock
resetN  in  1  reset, asynchronous, active-low
startOfFrame  in  1  one-clk pulse per frame
enable  in  1  level; 0 = obstacle parked at initial state
collision  in  1  level from collision detector; rising edge is the event
topLeftX  out  11 signed  pixel X = posX >>> FP_SHIFT
topLeftY  out  11 signed  pixel Y = posY >>> FP_SHIFT
frozen  out  1  high while in FROZEN
hitCount  out  8  number of accepted collisions, saturates at 255

Behaviour:
- Internal state: posX, posY, speedX, speedY as 32-bit signed; freezeCnt 8 bit; collision_d for edge detect.
- Reset (async): state=IDLE; posX=INITIAL_X<<FP_SHIFT; posY=INITIAL_Y<<FP_SHIFT; speeds=INITIAL_*_SPEED; freezeCnt=0; hitCount=0; collision_d=0.
- Reset output values: topLeftX=INITIAL_X, topLeftY=INITIAL_Y, frozen=0, hitCount=0.
- Outputs are combinational from the registers. Position output lags the startOfFrame pulse by 1 clk.
- The collision event is defined as collision & ~collision_d.
- States:
  - IDLE: hold initial position/speed values. Go to RUN on the clk where enable=1.
  - RUN: on startOfFrame, integrate position (rules below).
  - FROZEN: position held. On each startOfFrame, freezeCnt decrements. On a startOfFrame with freezeCnt==1, go to RUN; no move on that frame.
- Event in RUN:
  - Each speed magnitude becomes min(|v|+SPEED_ADDITION, MAX_SPEED); the sign is kept. A zero speed stays zero.
  - hitCount increments (saturating). freezeCnt=FREEZE_FRAMES. Go to FROZEN.
  - Priority: an event in the same clk as startOfFrame wins; no position update that frame.
- An event in FROZEN or IDLE is ignored: no speed change, no count.
- enable=0 in any state: go to IDLE next clk and reload the initial values. hitCount is kept; only resetN clears it.
- X integration, with nx=posX+speedX and XMAX=(FRAME_W-OBJECT_WIDTH_X)<<FP_SHIFT:
  - nx<0: posX=0, speedX=-speedX.
  - nx>XMAX: posX=XMAX, speedX=-speedX.
  - Otherwise posX=nx.
  - Clamping guarantees the object never renders outside the frame.
- Y integration, with ny=posY+speedY and YMAX=(FRAME_H-OBJECT_HEIGHT_Y)<<FP_SHIFT:
  - Y_WRAP=0: same clamp/negate rule as X, using YMAX.
  - Y_WRAP=1:
    - ny>FRAME_H<<FP_SHIFT: posY=-(OBJECT_HEIGHT_Y<<FP_SHIFT), so the object re-enters from the top.
    - ny<-(OBJECT_HEIGHT_Y<<FP_SHIFT): posY=FRAME_H<<FP_SHIFT.
    - Otherwise posY=ny.
    - topLeftY may therefore be negative.
- Division is an arithmetic shift (floor toward -inf). For example, posY=-1 gives topLeftY=-1.
- Reset asserted mid-freeze or mid-frame: immediate return to reset values; no pending event survives.

Test Plan:
- Defaults, enable=1, one startOfFrame: posX 6400->6520, so topLeftX=101; topLeftY=300 (speedY=0).
- Right wall: force posX near the limit, startOfFrame with nx=36900 > XMAX=36864 -> posX=36864, topLeftX=576, speedX=-120. Next frame: topLeftX=574.
- Collision edge in RUN -> speedX=130, hitCount=1, frozen=1. Exactly 8 startOfFrames with no movement, then RUN; the 9th frame moves by 130. A level held high during the freeze yields no second count.
- Saturation: 5 separated collisions -> speedX sequence 130,140,150,160,160; hitCount=5.
- Y_WRAP=1, INITIAL_Y_SPEED=64, posY=480*64 then one frame -> topLeftY=-32. Simultaneous collision+startOfFrame -> no move, FROZEN.
- enable dropped during FROZEN -> next clk IDLE, topLeftX=100, speedX=120, hitCount kept. resetN low -> hitCount=0 asynchronously.
